// File: rtl/timer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// timer_ctrl_pkg
// Shared definitions for the interval timer.
//   state_t : 2-bit controller state; the encodings are visible on the
//             timer's state output (IDLE=00, RUN=01, HOLD=10, DONE=11).
// ----------------------------------------------------------------------------
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/timer_ctrl_period_cnt.sv
// ----------------------------------------------------------------------------
// period_cnt
// SIZE-wide up counter with a synchronous clear and a count enable.
// Clear takes priority over enable. Arithmetic wraps modulo 2^SIZE.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, forces cnt to 0
//   en   : increment cnt by one on this edge
//   clr  : synchronously load 0 on this edge (wins over en)
//   cnt  : registered count value
// ----------------------------------------------------------------------------
module period_cnt #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    output logic [SIZE-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + SIZE'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// ----------------------------------------------------------------------------
// timer_ctrl
// Programmable interval timer with one-shot and periodic modes, pause/resume
// and abort. The period and mode are captured at launch; the count lives in
// a period_cnt instance driven by this controller.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : launch from IDLE/DONE (period must be non-zero), resume from HOLD
//   stop   : abort to IDLE from any state (highest priority)
//   pause  : freeze counting while in RUN (enters HOLD)
//   mode   : 0 = one-shot, 1 = periodic; captured at launch
//   period : cycles per interval; captured at launch
//   cnt    : current count
//   tick   : one-cycle pulse in the cycle after a terminal count
//   busy   : high in RUN or HOLD
//   state  : IDLE=00, RUN=01, HOLD=10, DONE=11
// ----------------------------------------------------------------------------
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            pause,
    input  logic            mode,
    input  logic [SIZE-1:0] period,
    output logic [SIZE-1:0] cnt,
    output logic            tick,
    output logic            busy,
    output logic [1:0]      state
);

    state_t          state_q;
    logic [SIZE-1:0] period_q;
    logic            mode_q;
    logic            tick_q;
    logic            at_term;
    logic            launch_ok;
    logic            cnt_en;
    logic            cnt_clr;

    // at_term is only meaningful in RUN; period_q is never 0 there, so the
    // subtraction cannot wrap while it matters.
    assign at_term   = (cnt == (period_q - SIZE'(1)));
    assign launch_ok = start && (period != '0);

    // Counter control follows the same priority as the FSM:
    // stop > pause > terminal > increment.
    always_comb begin
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        if (stop) begin
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (launch_ok) begin
                        cnt_clr = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!pause) begin
                        if (at_term) begin
                            // Periodic wraps to 0; one-shot holds period_q-1.
                            cnt_clr = mode_q;
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    period_cnt #(
        .SIZE (SIZE)
    ) u_period_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .cnt (cnt)
    );

    // Controller FSM with the period/mode latches and the tick register.
    // tick defaults low every edge so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (stop) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (launch_ok) begin
                            period_q <= period;
                            mode_q   <= mode;
                            state_q  <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            state_q <= ST_HOLD;
                        end else if (at_term) begin
                            tick_q <= 1'b1;
                            if (!mode_q) begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (start && !pause) begin
                            state_q <= ST_RUN;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tick  = tick_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign state = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_timer_ctrl
// Self-checking bench for timer_ctrl (SIZE=8). A table of stimulus/expected
// records is applied one per clock; each applied record pushes its expected
// outputs to a scoreboard queue that is popped and compared after the edge.
// Hand-written sequences cover the long periodic run, period=255 and the
// asynchronous reset cases.
// ----------------------------------------------------------------------------
module tb_timer_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic       mode;
    logic [7:0] period;
    logic [7:0] cnt;
    logic       tick;
    logic       busy;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;
    int ticks_seen;

    typedef struct {
        string      name;
        logic       start;
        logic       stop;
        logic       pause;
        logic       mode;
        logic [7:0] period;
        logic [1:0] st;
        logic [7:0] cnt;
        logic       tick;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [7:0] cnt;
        logic       tick;
        logic       busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    timer_ctrl #(
        .SIZE (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .mode   (mode),
        .period (period),
        .cnt    (cnt),
        .tick   (tick),
        .busy   (busy),
        .state  (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string n, logic s, logic sp, logic pa, logic m,
                                logic [7:0] p, logic [1:0] st, logic [7:0] c, logic t);
        vec_t v;
        v.name   = n;
        v.start  = s;
        v.stop   = sp;
        v.pause  = pa;
        v.mode   = m;
        v.period = p;
        v.st     = st;
        v.cnt    = c;
        v.tick   = t;
        return v;
    endfunction

    function automatic void add(string n, logic s, logic sp, logic pa, logic m,
                                logic [7:0] p, logic [1:0] st, logic [7:0] c, logic t);
        tbl.push_back(mk(n, s, sp, pa, m, p, st, c, t));
    endfunction

    function automatic void compare(string n, string field, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0d expected %0d", n, field, act, exp);
        end
    endfunction

    function automatic void check_now(string n, logic [1:0] st, logic [7:0] c, logic t, logic b);
        compare(n, "state", 32'(state), 32'(st));
        compare(n, "cnt",   32'(cnt),   32'(c));
        compare(n, "tick",  32'(tick),  32'(t));
        compare(n, "busy",  32'(busy),  32'(b));
    endfunction

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected one entry");
            return;
        end
        e = sb.pop_front();
        check_now(e.name, e.st, e.cnt, e.tick, e.busy);
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        start  = v.start;
        stop   = v.stop;
        pause  = v.pause;
        mode   = v.mode;
        period = v.period;
        e.name = v.name;
        e.st   = v.st;
        e.cnt  = v.cnt;
        e.tick = v.tick;
        e.busy = (v.st == S_RUN) || (v.st == S_HOLD);
        sb.push_back(e);
        @(posedge clk);
        #1;
        ticks_seen += int'(tick);
        check_output();
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        pause  = 1'b0;
        mode   = 1'b0;
        period = 8'd0;
        ticks_seen = 0;

        // One-shot, period 4; later period/start changes must not matter.
        add("os_launch",   1, 0, 0, 0, 8'd4, S_RUN,  8'd0, 0);
        add("os_c1",       0, 0, 0, 1, 8'd9, S_RUN,  8'd1, 0);
        add("os_c2",       0, 0, 0, 0, 8'd9, S_RUN,  8'd2, 0);
        add("os_startrun", 1, 0, 0, 0, 8'd9, S_RUN,  8'd3, 0);
        add("os_term",     0, 0, 0, 0, 8'd9, S_DONE, 8'd3, 1);
        add("os_done",     0, 0, 0, 0, 8'd9, S_DONE, 8'd3, 0);
        add("os_pausedone",0, 0, 1, 0, 8'd9, S_DONE, 8'd3, 0);
        add("zero_done",   1, 0, 0, 0, 8'd0, S_DONE, 8'd3, 0);
        add("stop_done",   0, 1, 0, 0, 8'd0, S_IDLE, 8'd0, 0);
        add("zero_idle",   1, 0, 0, 0, 8'd0, S_IDLE, 8'd0, 0);
        // Pause at cnt=2 for four cycles, resume with a different period.
        add("pr_launch",   1, 0, 0, 0, 8'd5, S_RUN,  8'd0, 0);
        add("pr_c1",       0, 0, 0, 0, 8'd5, S_RUN,  8'd1, 0);
        add("pr_c2",       0, 0, 0, 0, 8'd5, S_RUN,  8'd2, 0);
        add("pr_hold1",    0, 0, 1, 0, 8'd5, S_HOLD, 8'd2, 0);
        add("pr_hold2",    0, 0, 1, 0, 8'd5, S_HOLD, 8'd2, 0);
        add("pr_hold3",    0, 0, 1, 0, 8'd5, S_HOLD, 8'd2, 0);
        add("pr_hold4",    0, 0, 1, 0, 8'd5, S_HOLD, 8'd2, 0);
        add("pr_startpau", 1, 0, 1, 0, 8'd5, S_HOLD, 8'd2, 0);
        add("pr_resume",   1, 0, 0, 1, 8'd7, S_RUN,  8'd2, 0);
        add("pr_c3",       0, 0, 0, 1, 8'd7, S_RUN,  8'd3, 0);
        add("pr_c4",       0, 0, 0, 1, 8'd7, S_RUN,  8'd4, 0);
        add("pr_term",     0, 0, 0, 1, 8'd7, S_DONE, 8'd4, 1);
        add("pr_done",     0, 0, 0, 1, 8'd7, S_DONE, 8'd4, 0);
        // Pause colliding with terminal, then stop colliding with terminal.
        add("col_launch",  1, 0, 0, 1, 8'd3, S_RUN,  8'd0, 0);
        add("col_c1",      0, 0, 0, 1, 8'd3, S_RUN,  8'd1, 0);
        add("col_c2",      0, 0, 0, 1, 8'd3, S_RUN,  8'd2, 0);
        add("col_pause",   0, 0, 1, 1, 8'd3, S_HOLD, 8'd2, 0);
        add("col_resume",  1, 0, 0, 1, 8'd3, S_RUN,  8'd2, 0);
        add("col_term",    0, 0, 0, 1, 8'd3, S_RUN,  8'd0, 1);
        add("col_c1b",     0, 0, 0, 1, 8'd3, S_RUN,  8'd1, 0);
        add("col_c2b",     0, 0, 0, 1, 8'd3, S_RUN,  8'd2, 0);
        add("col_stop",    1, 1, 0, 1, 8'd3, S_IDLE, 8'd0, 0);
        add("col_idle",    0, 0, 0, 1, 8'd3, S_IDLE, 8'd0, 0);
        // Stop out of HOLD.
        add("sh_launch",   1, 0, 0, 0, 8'd2, S_RUN,  8'd0, 0);
        add("sh_pause",    0, 0, 1, 0, 8'd2, S_HOLD, 8'd0, 0);
        add("sh_stop",     0, 1, 1, 0, 8'd2, S_IDLE, 8'd0, 0);
        // Period 1 periodic: tick every cycle after the first.
        add("p1_launch",   1, 0, 0, 1, 8'd1, S_RUN,  8'd0, 0);
        add("p1_t1",       0, 0, 0, 1, 8'd1, S_RUN,  8'd0, 1);
        add("p1_t2",       0, 0, 0, 1, 8'd1, S_RUN,  8'd0, 1);
        add("p1_t3",       0, 0, 0, 0, 8'd1, S_RUN,  8'd0, 1);
        add("p1_stop",     0, 1, 0, 0, 8'd1, S_IDLE, 8'd0, 0);

        #2;
        check_now("reset_async", S_IDLE, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply_stimulus(tbl[i]);
        end

        // Periodic period 3 for ten intervals.
        apply_stimulus(mk("per3_launch", 1, 0, 0, 1, 8'd3, S_RUN, 8'd0, 0));
        ticks_seen = 0;
        for (int k = 1; k <= 30; k++) begin
            apply_stimulus(mk("per3_run", 0, 0, 0, 1, 8'd3, S_RUN,
                              8'(k % 3), 1'((k % 3) == 0)));
        end
        compare("per3", "tick_count", 32'(ticks_seen), 32'd10);
        apply_stimulus(mk("per3_stop", 0, 1, 0, 1, 8'd3, S_IDLE, 8'd0, 0));

        // Period 255 one-shot: terminal at 254, no wrap.
        apply_stimulus(mk("p255_launch", 1, 0, 0, 0, 8'd255, S_RUN, 8'd0, 0));
        for (int k = 1; k <= 254; k++) begin
            apply_stimulus(mk("p255_run", 0, 0, 0, 0, 8'd255, S_RUN, 8'(k), 0));
        end
        apply_stimulus(mk("p255_term", 0, 0, 0, 0, 8'd255, S_DONE, 8'd254, 1));
        apply_stimulus(mk("p255_done", 0, 0, 0, 0, 8'd255, S_DONE, 8'd254, 0));
        apply_stimulus(mk("p255_stop", 0, 1, 0, 0, 8'd255, S_IDLE, 8'd0, 0));

        // Async reset between edges while a terminal is pending.
        apply_stimulus(mk("ar_launch", 1, 0, 0, 1, 8'd4, S_RUN, 8'd0, 0));
        apply_stimulus(mk("ar_c1",     0, 0, 0, 1, 8'd4, S_RUN, 8'd1, 0));
        apply_stimulus(mk("ar_c2",     0, 0, 0, 1, 8'd4, S_RUN, 8'd2, 0));
        apply_stimulus(mk("ar_c3",     0, 0, 0, 1, 8'd4, S_RUN, 8'd3, 0));
        #2;
        rst = 1'b1;
        #1;
        check_now("ar_immediate", S_IDLE, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_now("ar_held", S_IDLE, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        apply_stimulus(mk("ar_rel1", 0, 0, 0, 1, 8'd4, S_IDLE, 8'd0, 0));
        apply_stimulus(mk("ar_rel2", 0, 0, 0, 1, 8'd4, S_IDLE, 8'd0, 0));
        apply_stimulus(mk("ar_relaunch", 1, 0, 0, 0, 8'd2, S_RUN, 8'd0, 0));
        apply_stimulus(mk("ar_rc1",      0, 0, 0, 0, 8'd2, S_RUN, 8'd1, 0));
        apply_stimulus(mk("ar_rterm",    0, 0, 0, 0, 8'd2, S_DONE, 8'd1, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter: SIZE, default 8, width of the count and period.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  level-sampled; launch from IDLE/DONE, resume from HOLD.
REQ-005 stop  input  1  level-sampled; abort to IDLE from any state.
REQ-006 pause  input  1  level-sampled; freeze counting while in RUN.
REQ-007 mode  input  1  0 = one-shot, 1 = periodic; sampled with period at launch.
REQ-008 period  input  SIZE  terminal count; number of cycles per interval.
REQ-009 cnt  output  SIZE  current count, registered.
REQ-010 tick  output  1  registered one-cycle pulse, high for the cycle after a terminal count.
REQ-011 busy  output  1  high in RUN or HOLD.
REQ-012 state  output  2  encoding: IDLE=00, RUN=01, HOLD=10, DONE=11.

Function
REQ-013 Launch: in IDLE or DONE, start=1 with period!=0 shall latch period_q/mode_q, set cnt<=0, enter RUN on the same edge.
REQ-014 In IDLE or DONE, start=1 with period==0 shall be ignored; state, cnt and period_q shall be unchanged.
REQ-015 In RUN, absent stop/pause/terminal, cnt shall increment by 1 per cycle.
REQ-016 Terminal condition: RUN and cnt==period_q-1, evaluated at the edge; tick shall be 1 in the following cycle only.
REQ-017 Terminal with mode_q=1: cnt<=0, remain RUN; ticks recur every period_q cycles.
REQ-018 Terminal with mode_q=0: enter DONE, cnt holds period_q-1.
REQ-019 period_q=1 in periodic mode: cnt stays 0, tick high every cycle after the first.
REQ-020 Priority per edge: stop > pause > terminal > increment.
REQ-021 stop=1 in any state: next state IDLE, cnt<=0, tick<=0, even if terminal or start coincide.
REQ-022 pause=1 in RUN: enter HOLD, cnt held; a coincident terminal is suppressed and no tick is issued.
REQ-023 In HOLD: cnt held; start=1 with pause=0 shall return to RUN, with no relatch of period or mode.
REQ-024 After resume from HOLD at cnt==period_q-1, the terminal shall occur on the first RUN edge.
REQ-025 start in RUN shall be ignored; changes to period or mode after launch shall have no effect until the next launch.
REQ-026 pause outside RUN shall be ignored.
REQ-027 cnt arithmetic is modulo 2^SIZE; cnt never exceeds period_q-1 by construction.

Reset
REQ-028 rst=1 shall immediately force state=IDLE, cnt=0, tick=0, busy=0, period_q=0, mode_q=0, independent of clk.
REQ-029 Reset asserted mid-RUN or mid-HOLD shall abandon the interval; no tick shall be issued on reset release.
REQ-030 First launch shall be possible on the first rising edge after rst deasserts.

Structure
REQ-031 A shared package shall hold the 2-bit state enumeration and its encodings.
REQ-032 The count register shall be a sub-module, period_cnt: SIZE-wide, with enable and synchronous clear.
REQ-033 The FSM, period/mode latches and tick register shall reside in timer_ctrl.

Verification
REQ-034 One-shot: SIZE=8, period=4, mode=0, 1-cycle start -> cnt 0,1,2,3; tick high once; state DONE with cnt=3; busy low.
REQ-035 Periodic: period=3, mode=1 -> tick every 3 cycles for 10 intervals; cnt sequence 0,1,2,0,...
REQ-036 Pause/resume: period=5, pause at cnt=2 for 4 cycles -> cnt holds 2, state HOLD; start resumes; tick 3 cycles later; total 5 counting cycles.
REQ-037 Collisions: pause at cnt=period_q-1 -> no tick, HOLD; stop coinciding with terminal -> IDLE, cnt=0, no tick.
REQ-038 Edges: start with period=0 -> stays IDLE; period=1 periodic -> tick every cycle; period=255 -> correct terminal with no wrap.
REQ-039 Async reset mid-RUN between clock edges -> outputs zero immediately; no tick after release.
